// File: rtl/cell_vector_sequencer.sv
// Exhaustive vector sequencer for a combinational library cell: walks every input vector,
// compares the cell output with a golden truth table. Optional capture map: CELL_SEQ_LOG_EN.
module cell_vector_sequencer #(
  parameter int unsigned        N_IN      = 4,
  parameter int unsigned        SETTLE    = 2,
  parameter logic [2**N_IN-1:0] EXP_TRUTH = 16'h0777
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic              ZN_IN,
  output logic [N_IN-1:0]   DRV,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [N_IN:0]     ERR_CNT,
  output logic [N_IN-1:0]   FAIL_VEC
`ifdef CELL_SEQ_LOG_EN
  ,
  output logic [2**N_IN-1:0] CAP
`endif
);

  localparam int unsigned NVec = 2 ** N_IN;
  localparam int unsigned CntW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleC = CntW'(SETTLE);
  localparam logic [N_IN-1:0] LastVec = N_IN'(NVec - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] drv_q, drv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            mismatch;
`ifdef CELL_SEQ_LOG_EN
  logic [NVec-1:0] cap_q, cap_d;
`endif

  // Case inequality so an X/Z from the cell counts as a failure.
  assign mismatch = (ZN_IN !== EXP_TRUTH[drv_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
`ifdef CELL_SEQ_LOG_EN
    cap_d   = cap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StRun;
          drv_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
`ifdef CELL_SEQ_LOG_EN
          cap_d   = '0;
`endif
        end
      end
      StRun: begin
        if (cnt_q == SettleC) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) fail_d = drv_q;
          end
`ifdef CELL_SEQ_LOG_EN
          cap_d[drv_q] = ZN_IN;
`endif
          cnt_d = '0;
          if (drv_q == LastVec) state_d = StFin;
          else                  drv_d   = drv_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        drv_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
`ifdef CELL_SEQ_LOG_EN
      cap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
`ifdef CELL_SEQ_LOG_EN
      cap_q   <= cap_d;
`endif
    end
  end

  assign DRV      = drv_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_q;
`ifdef CELL_SEQ_LOG_EN
  assign CAP      = cap_q;
`endif

endmodule
